// File: rtl/fetch_queue_unit.sv
// Fetch stage: owns the PC, issues in-order imem word requests, queues {instr, pc}.
// Optional misaligned-redirect check/halt enabled by `define FETCH_MISALIGN_CHK_EN.
module fetch_queue_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        misalign
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned CW1 = CW + 1;

  typedef enum logic {RUN, HALT} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] discard;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          misalign_q;

  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];

  logic [31:0]   tgt_pc;
  logic          tgt_bad;
  logic [CW:0]   occ;
  logic          credit_ok;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic [CW-1:0] inflight_nxt;

`ifdef FETCH_MISALIGN_CHK_EN
  assign tgt_pc  = redirect_pc;
  assign tgt_bad = redirect_pc[1:0] != 2'b00;
`else
  assign tgt_pc  = redirect_pc & ~32'd3;
  assign tgt_bad = 1'b0;
`endif

  // Credits cover both queued and in-flight words, so a push never overflows.
  assign occ       = {1'b0, inflight} + {1'b0, count};
  assign credit_ok = occ < CW1'(DEPTH);

  assign imem_req_valid = !rst && (state == RUN)
                       && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign out_valid = count != '0;
  assign pop       = out_valid && out_ready;
  assign push      = imem_rsp_valid && (discard == '0)
                  && !redirect_valid;

  assign inflight_nxt = inflight + CW'(req_fire)
                      - CW'(imem_rsp_valid);

  assign out_instr    = out_valid ? instr_q[rd_ptr] : '0;
  assign out_pc       = out_valid ? pc_q[rd_ptr] : '0;
  assign out_pc_plus4 = out_valid ? pc_q[rd_ptr] + 32'd4 : '0;
  assign misalign     = misalign_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      fetch_pc   <= RESET_PC;
      rsp_pc     <= RESET_PC;
      inflight   <= '0;
      discard    <= '0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      misalign_q <= 1'b0;
    end else begin
      inflight <= inflight_nxt;
      if (redirect_valid) begin
        // Everything still outstanding belongs to the old path.
        fetch_pc   <= tgt_pc;
        rsp_pc     <= tgt_pc;
        discard    <= inflight_nxt;
        count      <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        misalign_q <= tgt_bad;
        state      <= tgt_bad ? HALT : RUN;
      end else begin
        if (req_fire)
          fetch_pc <= fetch_pc + 32'd4;
        if (imem_rsp_valid && (discard != '0))
          discard <= discard - CW'(1);
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
          rsp_pc <= rsp_pc + 32'd4;
        end
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr] <= imem_rsp_data;
      pc_q[wr_ptr]    <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: latency-programmable imem model plus a
// scoreboard of expected {pc, instr} pushed at request time.
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        misalign;

  int checks = 0;
  int failures = 0;
  int lat = 1;
  int cyc = 0;
  int n_out = 0;
  int n_fire = 0;

  logic [31:0] exp_q[$];
  logic [31:0] fire_q[$];
  logic [31:0] out_log[$];
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] model_pc = '0;
  logic        model_halt = 1'b0;
  logic [31:0] e;
  logic [31:0] dummy_a;
  int          dummy_d;

  fetch_queue_unit #(
    .RESET_PC(32'h0000_0000),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .out_pc_plus4(out_pc_plus4),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9bdf;
  endfunction

  // imem: present the oldest due response for the whole cycle
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mq_addr.delete();
      mq_due.delete();
      model_pc   = 32'h0;
      model_halt = 1'b0;
    end else begin
      if (imem_rsp_valid && mq_addr.size() != 0) begin
        dummy_a = mq_addr.pop_front();
        dummy_d = mq_due.pop_front();
      end
      if (out_valid && out_ready) begin
        n_out++;
        out_log.push_back(out_pc);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL out_extra pc=%h instr=%h required none", out_pc, out_instr);
        end else begin
          e = exp_q.pop_front();
          if (out_pc !== e || out_instr !== mem_word(e) || out_pc_plus4 !== e + 32'd4) begin
            failures++;
            $display("FAIL out_stream pc=%h instr=%h pc4=%h required pc=%h instr=%h pc4=%h",
                     out_pc, out_instr, out_pc_plus4, e, mem_word(e), e + 32'd4);
          end
        end
      end
      if (redirect_valid) begin
        checks++;
        if (imem_req_valid !== 1'b0) begin
          failures++;
          $display("FAIL req_in_redirect valid=%b required 0", imem_req_valid);
        end
        exp_q.delete();
`ifdef FETCH_MISALIGN_CHK_EN
        if (redirect_pc[1:0] != 2'b00) model_halt = 1'b1;
        else begin
          model_halt = 1'b0;
          model_pc   = redirect_pc;
        end
`else
        model_pc = redirect_pc & ~32'd3;
`endif
      end else if (imem_req_valid && imem_req_ready) begin
        n_fire++;
        fire_q.push_back(imem_req_addr);
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(cyc + lat);
        checks++;
        if (model_halt || imem_req_addr !== model_pc) begin
          failures++;
          $display("FAIL req_addr addr=%h halt=%b required addr=%h", imem_req_addr, model_halt, model_pc);
        end
        exp_q.push_back(model_pc);
        model_pc = model_pc + 32'd4;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset(input int l, input logic rdy);
    rst = 1'b1;
    redirect_valid = 1'b0;
    out_ready = rdy;
    lat = l;
    tick(2);
    rst = 1'b0;
    n_out = 0;
    n_fire = 0;
    fire_q.delete();
    out_log.delete();
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    fire_q.delete();
    out_log.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    checks++;
    if ({imem_req_valid, out_valid, misalign} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags req=%b out=%b mis=%b required 000", imem_req_valid, out_valid, misalign);
    end
    checks++;
    if (imem_req_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_addr addr=%h required 00000000", imem_req_addr);
    end
    checks++;
    if ({out_instr, out_pc, out_pc_plus4} !== 96'h0) begin
      failures++;
      $display("FAIL reset_out instr=%h pc=%h pc4=%h required 0", out_instr, out_pc, out_pc_plus4);
    end
  endtask

  task automatic test_stream();
    apply_reset(1, 1'b1);
    tick(12);
    checks++;
    if (n_fire != 12) begin
      failures++;
      $display("FAIL stream_fires got=%0d required 12", n_fire);
    end
    checks++;
    if (n_out != 10) begin
      failures++;
      $display("FAIL stream_outs got=%0d required 10", n_out);
    end
    checks++;
    if (fire_q.size() < 3 || fire_q[0] !== 32'h0 || fire_q[1] !== 32'h4 || fire_q[2] !== 32'h8) begin
      failures++;
      $display("FAIL stream_addrs n=%0d required 0,4,8", fire_q.size());
    end
    checks++;
    if (out_log.size() < 3 || out_log[0] !== 32'h0 || out_log[1] !== 32'h4 || out_log[2] !== 32'h8) begin
      failures++;
      $display("FAIL stream_pcs n=%0d required 0,4,8", out_log.size());
    end
  endtask

  task automatic test_backpressure();
    apply_reset(1, 1'b0);
    tick(10);
    checks++;
    if (n_fire != 4) begin
      failures++;
      $display("FAIL bp_fires got=%0d required 4", n_fire);
    end
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== mem_word(32'h0)) begin
      failures++;
      $display("FAIL bp_hold valid=%b pc=%h instr=%h required 1 0 %h", out_valid, out_pc, out_instr, mem_word(32'h0));
    end
    out_ready = 1'b1;
    n_out = 0;
    out_log.delete();
    tick(10);
    checks++;
    if (n_out != 10) begin
      failures++;
      $display("FAIL bp_release_outs got=%0d required 10", n_out);
    end
    checks++;
    if (out_log.size() < 5 || out_log[0] !== 32'h0 || out_log[3] !== 32'hc || out_log[4] !== 32'h10) begin
      failures++;
      $display("FAIL bp_release_order n=%0d required 0,4,8,c,10", out_log.size());
    end
  endtask

  task automatic test_redirect_inflight();
    logic found;
    apply_reset(3, 1'b1);
    tick(4);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (mq_addr.size() == 3) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rdir_setup inflight=%0d required 3", mq_addr.size());
    end
    do_redirect(32'h100);
    tick(14);
    checks++;
    if (fire_q.size() == 0 || fire_q[0] !== 32'h100) begin
      failures++;
      $display("FAIL rdir_req n=%0d required 00000100", fire_q.size());
    end
    checks++;
    if (out_log.size() == 0 || out_log[0] !== 32'h100) begin
      failures++;
      $display("FAIL rdir_out n=%0d required 00000100", out_log.size());
    end
  endtask

  task automatic test_same_cycle();
    logic found;
    int n0;
    apply_reset(1, 1'b1);
    tick(6);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (out_valid && imem_rsp_valid) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL same_setup out=%b rsp=%b required 1 1", out_valid, imem_rsp_valid);
    end
    n0 = n_out;
    do_redirect(32'h400);
    checks++;
    if (n_out != n0 + 1) begin
      failures++;
      $display("FAIL same_handshake got=%0d required %0d", n_out, n0 + 1);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL same_flush valid=%b required 0", out_valid);
    end
    tick(8);
    checks++;
    if (out_log.size() == 0 || out_log[0] !== 32'h400) begin
      failures++;
      $display("FAIL same_restart n=%0d required 00000400", out_log.size());
    end
  endtask

  task automatic test_wrap();
    do_redirect(32'hffff_fff8);
    tick(8);
    checks++;
    if (fire_q.size() < 3 || fire_q[0] !== 32'hffff_fff8 || fire_q[1] !== 32'hffff_fffc || fire_q[2] !== 32'h0) begin
      failures++;
      $display("FAIL wrap_req n=%0d required fffffff8,fffffffc,0", fire_q.size());
    end
    checks++;
    if (out_log.size() < 3 || out_log[1] !== 32'hffff_fffc || out_log[2] !== 32'h0) begin
      failures++;
      $display("FAIL wrap_out n=%0d required fffffff8,fffffffc,0", out_log.size());
    end
  endtask

  task automatic test_misalign();
    do_redirect(32'h102);
`ifdef FETCH_MISALIGN_CHK_EN
    n_fire = 0;
    checks++;
    if (misalign !== 1'b1 || imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL mis_set mis=%b req=%b required 1 0", misalign, imem_req_valid);
    end
    tick(6);
    checks++;
    if (n_fire != 0 || out_valid !== 1'b0 || misalign !== 1'b1) begin
      failures++;
      $display("FAIL mis_halt fires=%0d out=%b mis=%b required 0 0 1", n_fire, out_valid, misalign);
    end
    do_redirect(32'h200);
    checks++;
    if (misalign !== 1'b0) begin
      failures++;
      $display("FAIL mis_clear mis=%b required 0", misalign);
    end
    tick(6);
    checks++;
    if (fire_q.size() == 0 || fire_q[0] !== 32'h200 || out_log.size() == 0 || out_log[0] !== 32'h200) begin
      failures++;
      $display("FAIL mis_resume nreq=%0d nout=%0d required 00000200", fire_q.size(), out_log.size());
    end
`else
    checks++;
    if (misalign !== 1'b0) begin
      failures++;
      $display("FAIL mis_tied mis=%b required 0", misalign);
    end
    tick(6);
    checks++;
    if (fire_q.size() == 0 || fire_q[0] !== 32'h100 || out_log.size() == 0 || out_log[0] !== 32'h100) begin
      failures++;
      $display("FAIL mis_align nreq=%0d nout=%0d required 00000100", fire_q.size(), out_log.size());
    end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_same_cycle();
    test_wrap();
    test_misalign();
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
